// File: rtl/keystream_scheduler.sv
// Keystream scheduler: prefetches hash-generator bytes into a small FIFO and
// serves them one at a time to the encryption block, with flush and error tracking.
module keystream_scheduler #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       key_valid,
    input  logic       flush_pulse,
    input  logic       gen_ready,
    output logic       gen_request_pulse,
    input  logic [7:0] gen_byte,
    input  logic       gen_byte_pulse,
    input  logic       ks_request_pulse,
    output logic [7:0] ks_byte,
    output logic       ks_byte_pulse,
    output logic [4:0] level,
    output logic       busy,
    output logic [2:0] error_flags
);
    localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]      DEPTH_L = 5'(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE = AW'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    level_q, level_d;
    logic          pending_q, pending_d;
    logic [7:0]    wait_cnt_q, wait_cnt_d;
    logic [2:0]    err_q, err_d;
    logic [7:0]    ks_byte_q, ks_byte_d;
    logic          ks_pulse_q, ks_pulse_d;
    logic [7:0]    mem [DEPTH];

    logic issue, byte_in, req_new, want, bypass, fifo_wr, fifo_rd;

    // NOTE: every signal driven here gets a default first so no latch is inferred,
    // and only blocking assignments are used in combinational logic.
    always_comb begin
        issue   = (state_q == ST_IDLE) && key_valid && gen_ready &&
                  (level_q < DEPTH_L) && !flush_pulse && !nrst;
        byte_in = gen_byte_pulse && (state_q == ST_WAIT) && !flush_pulse;
        req_new = ks_request_pulse && !pending_q;
        // A waiting consumer takes an arriving byte directly, so level never blips.
        want    = pending_q || (req_new && !flush_pulse && (level_q == 5'd0));
        bypass  = byte_in && want;
        fifo_wr = byte_in && !want;
        fifo_rd = req_new && !flush_pulse && (level_q != 5'd0);

        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        ks_byte_d  = ks_byte_q;
        ks_pulse_d = fifo_rd || bypass;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q + 5'(fifo_wr) - 5'(fifo_rd);
        pending_d  = pending_q;

        if (fifo_rd) begin
            ks_byte_d = mem[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
        end else if (bypass) begin
            ks_byte_d = gen_byte;
        end
        if (fifo_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;

        if (bypass) pending_d = 1'b0;
        if (ks_request_pulse && pending_q) err_d[1] = 1'b1;
        if (req_new && (flush_pulse || level_q == 5'd0) && !bypass) pending_d = 1'b1;

        if (flush_pulse) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (gen_byte_pulse) err_d[0] = 1'b1;
                if (issue) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT, ST_DRAIN: begin
                if (gen_byte_pulse) begin
                    state_d = ST_IDLE;
                end else if (flush_pulse && state_q == ST_WAIT) begin
                    state_d    = ST_DRAIN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == 8'hFF) begin
                    state_d  = ST_IDLE;
                    err_d[2] = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            pending_q  <= 1'b0;
            wait_cnt_q <= '0;
            err_q      <= '0;
            ks_byte_q  <= 8'h00;
            ks_pulse_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            pending_q  <= pending_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
            ks_byte_q  <= ks_byte_d;
            ks_pulse_q <= ks_pulse_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; pointers and level define which entries are valid.
    always_ff @(posedge clk) begin
        if (fifo_wr) mem[wr_ptr_q] <= gen_byte;
    end

    assign gen_request_pulse = issue;
    assign ks_byte           = ks_byte_q;
    assign ks_byte_pulse     = ks_pulse_q;
    assign level             = level_q;
    assign busy              = (state_q != ST_IDLE);
    assign error_flags       = err_q;
endmodule

// File: tb/tb_keystream_scheduler.sv
// Self-checking bench for keystream_scheduler: directed scenarios plus a random run
// against a queue-based reference model with a reactive hash-generator agent.
`timescale 1ns/1ps
module tb_keystream_scheduler;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       nrst = 1'b1;
    logic       key_valid = 1'b0, flush_pulse = 1'b0, gen_ready = 1'b0;
    logic       gen_request_pulse;
    logic [7:0] gen_byte = 8'h00;
    logic       gen_byte_pulse = 1'b0, ks_request_pulse = 1'b0;
    logic [7:0] ks_byte;
    logic       ks_byte_pulse;
    logic [4:0] level;
    logic       busy;
    logic [2:0] error_flags;

    always #5 clk = ~clk;

    keystream_scheduler #(.DEPTH(DEPTH)) dut (
        .clk(clk), .nrst(nrst), .key_valid(key_valid), .flush_pulse(flush_pulse),
        .gen_ready(gen_ready), .gen_request_pulse(gen_request_pulse),
        .gen_byte(gen_byte), .gen_byte_pulse(gen_byte_pulse),
        .ks_request_pulse(ks_request_pulse), .ks_byte(ks_byte),
        .ks_byte_pulse(ks_byte_pulse), .level(level), .busy(busy),
        .error_flags(error_flags)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: stored keystream as a queue; m_out 0=no request, 1=live, 2=flushed.
    logic [7:0] m_q[$];
    bit         m_pend = 0;
    int         m_out = 0, m_wait = 0;
    logic [2:0] m_err = 3'b000;
    logic [7:0] m_ks = 8'h00;
    logic       m_pulse = 1'b0, m_req = 1'b0;

    // Generator agent: answers each predicted request gen_lat cycles later.
    bit         auto_gen = 0;
    int         gen_lat = 2, gen_cnt = 0;
    logic [7:0] src[$];
    logic       obs_req;

    task automatic model_step();
        bit good;
        m_req = !nrst && (m_out == 0) && key_valid && gen_ready &&
                (m_q.size() < DEPTH) && !flush_pulse;
        if (nrst) begin
            m_q.delete(); m_pend = 0; m_out = 0; m_wait = 0;
            m_err = 3'b000; m_ks = 8'h00; m_pulse = 1'b0;
            return;
        end
        m_pulse = 1'b0;
        good = gen_byte_pulse && (m_out == 1) && !flush_pulse;
        if (gen_byte_pulse && m_out == 0) m_err[0] = 1'b1;
        if (ks_request_pulse) begin
            if (m_pend) m_err[1] = 1'b1;
            else if (!flush_pulse && m_q.size() > 0) begin
                m_ks = m_q.pop_front(); m_pulse = 1'b1;
            end else m_pend = 1;
        end
        if (good) begin
            if (m_pend) begin m_ks = gen_byte; m_pulse = 1'b1; m_pend = 0; end
            else m_q.push_back(gen_byte);
        end
        if (flush_pulse) m_q.delete();
        if (m_out != 0) begin
            if (gen_byte_pulse) m_out = 0;
            else if (flush_pulse && m_out == 1) begin m_out = 2; m_wait = 0; end
            else if (m_wait == 255) begin m_out = 0; m_err[2] = 1'b1; end
            else m_wait++;
        end
        if (m_req) begin m_out = 1; m_wait = 0; end
    endtask

    // Advance one clock: inputs are held from posedge+1, gen_request_pulse is sampled
    // just before the edge, registered outputs #1 after it; strobes then drop.
    task automatic tick();
        if (auto_gen && gen_cnt > 0) begin
            gen_cnt--;
            if (gen_cnt == 0) begin
                gen_byte_pulse = 1'b1;
                gen_byte = (src.size() > 0) ? src.pop_front() : 8'($urandom);
            end
        end
        #3;
        obs_req = gen_request_pulse;
        model_step();
        if (m_req && auto_gen) gen_cnt = gen_lat;
        @(posedge clk); #1;
        flush_pulse = 1'b0; ks_request_pulse = 1'b0; gen_byte_pulse = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            key_valid = 1'($urandom); gen_ready = 1'b1; flush_pulse = 1'($urandom);
            ks_request_pulse = 1'b1; gen_byte_pulse = 1'($urandom); gen_byte = 8'($urandom);
            tick();
            n_checks++;
            if (obs_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", obs_req); end
        end
        n_checks += 5;
        if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (error_flags !== 3'b000) begin n_fail++; $display("FAIL reset_err: got %b expected 000", error_flags); end
        if (ks_byte !== 8'h00) begin n_fail++; $display("FAIL reset_ks_byte: got %h expected 00", ks_byte); end
        if (ks_byte_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_ks_pulse: got %b expected 0", ks_byte_pulse); end
        nrst = 1'b0; key_valid = 1'b0; gen_ready = 1'b0;
    endtask

    task automatic test_fill();
        int nreq = 0;
        key_valid = 1'b1; gen_ready = 1'b1; auto_gen = 1; gen_lat = 2; gen_cnt = 0;
        src = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        for (int i = 0; i < 20; i++) begin
            tick();
            nreq += int'(obs_req);
            n_checks += 2;
            if (obs_req !== m_req) begin n_fail++; $display("FAIL fill_req: cycle %0d got %b expected %b", i, obs_req, m_req); end
            if (level !== 5'(m_q.size())) begin n_fail++; $display("FAIL fill_level: cycle %0d got %0d expected %0d", i, level, m_q.size()); end
        end
        n_checks += 3;
        if (nreq !== 4) begin n_fail++; $display("FAIL fill_req_count: got %0d expected 4", nreq); end
        if (level !== 5'd4) begin n_fail++; $display("FAIL fill_full_level: got %0d expected 4", level); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL fill_busy: got %b expected 0", busy); end
    endtask

    task automatic test_drain();
        int nreq = 0;
        gen_lat = 20;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] exp_b;
            exp_b = 8'hA1 + 8'(i);
            ks_request_pulse = 1'b1;
            tick();
            nreq += int'(obs_req);
            n_checks += 3;
            if (ks_byte_pulse !== 1'b1) begin n_fail++; $display("FAIL drain_pulse: pop %0d got %b expected 1", i, ks_byte_pulse); end
            if (ks_byte !== exp_b) begin n_fail++; $display("FAIL drain_byte: pop %0d got %h expected %h", i, ks_byte, exp_b); end
            if (level !== 5'(3 - i)) begin n_fail++; $display("FAIL drain_level: pop %0d got %0d expected %0d", i, level, 3 - i); end
            tick();
            nreq += int'(obs_req);
            n_checks++;
            if (ks_byte_pulse !== 1'b0) begin n_fail++; $display("FAIL drain_pulse_low: pop %0d got %b expected 0", i, ks_byte_pulse); end
        end
        n_checks += 2;
        if (nreq !== 1) begin n_fail++; $display("FAIL drain_refill_count: got %0d expected 1", nreq); end
        if (busy !== 1'b1) begin n_fail++; $display("FAIL drain_refill_busy: got %b expected 1", busy); end
    endtask

    task automatic test_pending();
        key_valid = 1'b0;
        repeat (25) tick();
        ks_request_pulse = 1'b1;
        tick();
        n_checks += 3;
        if (ks_byte_pulse !== 1'b1) begin n_fail++; $display("FAIL pend_pre_pulse: got %b expected 1", ks_byte_pulse); end
        if (ks_byte !== m_ks) begin n_fail++; $display("FAIL pend_pre_byte: got %h expected %h", ks_byte, m_ks); end
        if (level !== 5'd0) begin n_fail++; $display("FAIL pend_pre_level: got %0d expected 0", level); end
        src.push_back(8'h5C); gen_lat = 3;
        ks_request_pulse = 1'b1; key_valid = 1'b1; gen_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) begin
                key_valid = 1'b0;
                n_checks++;
                if (obs_req !== 1'b1) begin n_fail++; $display("FAIL pend_req: got %b expected 1", obs_req); end
            end
            n_checks += 2;
            if (ks_byte_pulse !== (k == 3)) begin n_fail++; $display("FAIL pend_pulse: step %0d got %b expected %b", k, ks_byte_pulse, (k == 3)); end
            if (level !== 5'd0) begin n_fail++; $display("FAIL pend_level: step %0d got %0d expected 0", k, level); end
            if (k == 3) begin
                n_checks++;
                if (ks_byte !== 8'h5C) begin n_fail++; $display("FAIL pend_byte: got %h expected 5c", ks_byte); end
            end
        end
    endtask

    task automatic test_flush();
        int t = 0;
        src = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hC1, 8'hC2};
        gen_lat = 2; key_valid = 1'b1; gen_ready = 1'b1;
        while (!(m_q.size() == 3 && m_out == 1) && t < 60) begin
            if (m_q.size() >= 2) gen_lat = 8;
            tick(); t++;
        end
        n_checks += 3;
        if (t >= 60) begin n_fail++; $display("FAIL flush_setup: timed out after %0d cycles", t); end
        if (level !== 5'd3) begin n_fail++; $display("FAIL flush_pre_level: got %0d expected 3", level); end
        if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_pre_busy: got %b expected 1", busy); end
        flush_pulse = 1'b1;
        tick();
        n_checks += 2;
        if (level !== 5'd0) begin n_fail++; $display("FAIL flush_level: got %0d expected 0", level); end
        if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_drain_busy: got %b expected 1", busy); end
        t = 0;
        while (m_q.size() == 0 && t < 60) begin
            tick(); t++;
            n_checks++;
            if (level !== 5'(m_q.size())) begin n_fail++; $display("FAIL flush_post_level: got %0d expected %0d", level, m_q.size()); end
        end
        key_valid = 1'b0;
        ks_request_pulse = 1'b1;
        tick();
        n_checks += 2;
        if (ks_byte_pulse !== 1'b1) begin n_fail++; $display("FAIL flush_serve_pulse: got %b expected 1", ks_byte_pulse); end
        if (ks_byte !== 8'hC1) begin n_fail++; $display("FAIL flush_serve_byte: got %h expected c1", ks_byte); end
    endtask

    task automatic test_errors();
        int t = 0;
        int busy_cycles = 0;
        key_valid = 1'b0;
        while ((m_q.size() != 0 || m_out != 0) && t < 100) begin
            ks_request_pulse = (m_q.size() != 0) && (t % 2 == 0);
            tick(); t++;
        end
        n_checks++;
        if (t >= 100) begin n_fail++; $display("FAIL err_setup: timed out after %0d cycles", t); end
        ks_request_pulse = 1'b1; tick();
        ks_request_pulse = 1'b1; tick();
        n_checks += 2;
        if (error_flags[1] !== 1'b1) begin n_fail++; $display("FAIL err_overrun: got %b expected 1", error_flags[1]); end
        if (ks_byte_pulse !== 1'b0) begin n_fail++; $display("FAIL err_overrun_pulse: got %b expected 0", ks_byte_pulse); end
        auto_gen = 0;
        gen_byte_pulse = 1'b1; gen_byte = 8'h77;
        tick();
        n_checks++;
        if (error_flags[0] !== 1'b1) begin n_fail++; $display("FAIL err_stray: got %b expected 1", error_flags[0]); end
        key_valid = 1'b1; gen_ready = 1'b1;
        tick();
        key_valid = 1'b0;
        n_checks++;
        if (obs_req !== 1'b1) begin n_fail++; $display("FAIL err_timeout_req: got %b expected 1", obs_req); end
        t = 0;
        while (busy === 1'b1 && t < 300) begin tick(); busy_cycles++; t++; end
        n_checks += 3;
        if (busy_cycles !== 256) begin n_fail++; $display("FAIL err_timeout_len: got %0d cycles expected 256", busy_cycles); end
        if (error_flags !== 3'b111) begin n_fail++; $display("FAIL err_flags: got %b expected 111", error_flags); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL err_idle: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_wait();
        int t = 0;
        auto_gen = 1; gen_lat = 2; gen_cnt = 0; key_valid = 1'b1; gen_ready = 1'b1;
        while (!(m_q.size() == 2 && m_out == 1) && t < 80) begin
            if (m_q.size() >= 1) gen_lat = 12;
            tick(); t++;
        end
        n_checks++;
        if (t >= 80) begin n_fail++; $display("FAIL rst_setup: timed out after %0d cycles", t); end
        nrst = 1'b1;
        tick();
        n_checks += 6;
        if (obs_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", obs_req); end
        if (level !== 5'd0) begin n_fail++; $display("FAIL rst_level: got %0d expected 0", level); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        if (error_flags !== 3'b000) begin n_fail++; $display("FAIL rst_err: got %b expected 000", error_flags); end
        if (ks_byte !== 8'h00) begin n_fail++; $display("FAIL rst_ks_byte: got %h expected 00", ks_byte); end
        if (ks_byte_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_ks_pulse: got %b expected 0", ks_byte_pulse); end
        nrst = 1'b0; key_valid = 1'b0;
        repeat (15) tick();
        n_checks += 2;
        if (error_flags !== 3'b001) begin n_fail++; $display("FAIL rst_late_byte: got %b expected 001", error_flags); end
        if (level !== 5'd0) begin n_fail++; $display("FAIL rst_late_level: got %0d expected 0", level); end
    endtask

    task automatic test_random();
        nrst = 1'b1; tick(); nrst = 1'b0;
        auto_gen = 1; gen_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            key_valid        = ($urandom_range(0, 7) != 0);
            gen_ready        = ($urandom_range(0, 3) != 0);
            flush_pulse      = ($urandom_range(0, 39) == 0);
            ks_request_pulse = ($urandom_range(0, 2) == 0);
            gen_lat          = $urandom_range(1, 5);
            tick();
            n_checks += 6;
            if (obs_req !== m_req) begin n_fail++; $display("FAIL rand_req: cycle %0d got %b expected %b", i, obs_req, m_req); end
            if (ks_byte_pulse !== m_pulse) begin n_fail++; $display("FAIL rand_pulse: cycle %0d got %b expected %b", i, ks_byte_pulse, m_pulse); end
            if (ks_byte !== m_ks) begin n_fail++; $display("FAIL rand_byte: cycle %0d got %h expected %h", i, ks_byte, m_ks); end
            if (level !== 5'(m_q.size())) begin n_fail++; $display("FAIL rand_level: cycle %0d got %0d expected %0d", i, level, m_q.size()); end
            if (busy !== (m_out != 0)) begin n_fail++; $display("FAIL rand_busy: cycle %0d got %b expected %b", i, busy, (m_out != 0)); end
            if (error_flags !== m_err) begin n_fail++; $display("FAIL rand_err: cycle %0d got %b expected %b", i, error_flags, m_err); end
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_fill();
        test_drain();
        test_pending();
        test_flush();
        test_errors();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
